mu0_boot_ctrl: RTL
==================

Name: mu0_boot_ctrl

Overview:
- Run controller for the MU0 system, sitting between the mu0 core, mu0_memory and a byte-wide program-load stream.
- Holds the core in reset and loads a program image into memory from address 0.
- Then releases the core, owns the memory port mux, counts execution cycles, and reports Halted completion or a watchdog timeout.
- Replaces the fixed-delay reset/finish sequencing currently done by hand in benches.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 16, memory word width (two bytes per word)
CNT_W, 16, cycle counter width
MAX_CYCLES, 1000, RUN cycles before timeout (must be ≤ 2^CNT_W-1)
RST_CYCLES, 2, cycles Cpu_reset is held after load, before RUN

Ports:
Clk  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  single-cycle pulse; begins load+run; honoured only in IDLE/DONE
Load_len  in  ADDR_W  words to load; sampled on accepted Start; 0 = run existing image
Byte_in  in  8  load stream data, high byte of each word first
Byte_valid  in  1  load stream valid
Byte_ready  out  1  load stream ready; byte transfers when valid&ready
Cpu_rd  in  1  mu0 Rd
Cpu_wr  in  1  mu0 Wr
Cpu_addr  in  ADDR_W  mu0 Address
Cpu_data_out  in  DATA_W  mu0 Data_out
Cpu_halted  in  1  mu0 Halted
Cpu_reset  out  1  to mu0 Reset (active high)
Mem_rd  out  1  to mu0_memory Rd
Mem_wr  out  1  to mu0_memory Wr
Mem_addr  out  ADDR_W  to mu0_memory Address
Mem_wdata  out  DATA_W  to mu0_memory write data
Busy  out  1  high in LOAD/RELEASE/RUN
Done  out  1  high in DONE
Timeout  out  1  sticky in DONE; set when watchdog expired
Cycles  out  CNT_W  RUN cycle count, held in DONE

Behaviour:
- States: IDLE, LOAD, WRITE, RELEASE, RUN, DONE.
- Reset (async): state=IDLE. Cpu_reset=1, Byte_ready=0, Mem_rd=Mem_wr=0, Mem_addr=0, Mem_wdata=0, Busy=Done=Timeout=0, Cycles=0, internal byte phase=0, load address=0.
- IDLE/DONE + Start:
  - Latch Load_len; clear Done, Timeout, Cycles; load address=0; Cpu_reset=1.
  - Go to LOAD if Load_len≠0, else RELEASE.
- LOAD:
  - Byte_ready=1.
  - Phase 0 accept: store hi byte, phase=1.
  - Phase 1 accept: store lo byte, go to WRITE.
  - Byte_valid low: stall indefinitely, no timeout.
- WRITE (exactly 1 cycle):
  - Byte_ready=0, Mem_wr=1, Mem_addr=load address, Mem_wdata={hi,lo}.
  - Load address increments and phase returns to 0.
  - If the words written now equal the latched length, go to RELEASE; else go to LOAD.
- RELEASE: Cpu_reset=1 for RST_CYCLES cycles with Mem_rd/Mem_wr=0, then go to RUN.
- RUN:
  - Cpu_reset=0.
  - Mem_rd/Mem_wr/Mem_addr/Mem_wdata are combinational passthrough of the Cpu_* inputs (zero added latency).
  - Cycles increments by 1 each RUN cycle.
  - Cpu_halted=1: go to DONE with Timeout=0.
  - Else Cycles==MAX_CYCLES-1: go to DONE with Timeout=1.
  - Halted and expiry in the same cycle: halt wins, Timeout=0.
- DONE:
  - Halted exit: Cpu_reset stays 0 so the core stays halted; memory passthrough stays active for inspection.
  - Timeout exit: Cpu_reset=1 and Mem_rd/Mem_wr=0.
  - Done=1.
- Start outside IDLE/DONE is ignored.
- Bytes offered outside LOAD are not accepted (Byte_ready=0).
- Load address never wraps, since Load_len ≤ 2^ADDR_W-1.
- Reset_n asserted mid-load or mid-run aborts immediately to the reset values above. Memory contents already written are kept.

Decomposition:
- Shared package mu0_pkg: state encoding constants, ADDR_W/DATA_W defaults, and the MU0 Halted/STP opcode constant used by the bench.
- One sub-module, mu0_byte_packer: byte stream to 16-bit word assembler (phase flag, hi register, word-valid pulse).
- Top FSM, mux and counter stay in mu0_boot_ctrl.

Test Plan:
- Load_len=3, bytes 00 05 10 06 70 00 continuous → WRITE cycles to addr 0,1,2 with data 0x0005, 0x1006, 0x7000; Cpu_reset low exactly RST_CYCLES+... after last write; Done=1, Timeout=0 once Halted.
- Same image with Byte_valid low for 5 cycles between bytes 3 and 4 → Byte_ready held high, no write until the 4th byte; identical memory contents.
- Load_len=0 with a pre-loaded looping program, MAX_CYCLES=20 → RUN 20 cycles; Timeout=1, Cycles=19, Cpu_reset=1, Mem_wr=0.
- Halted rises on the same cycle Cycles==MAX_CYCLES-1 → DONE, Timeout=0.
- Reset_n pulsed low during LOAD after 3 bytes, then Start with Load_len=1 (bytes AB CD) → addr 0 gets 0xABCD; the earlier partial word is never written.
- Start pulsed during RUN → ignored, Cycles continues monotonically; Start in DONE → Cycles cleared and a new load starts.

Source files
------------

// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 run controller: state encodings, default widths
// and the MU0 instruction helpers used when building program images.
package mu0_pkg;

    localparam int MU0_ADDR_W = 12;
    localparam int MU0_DATA_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // STP raises Halted on the core; opcode sits in the top nibble of the word.
    localparam logic [3:0] MU0_OP_STP = 4'h7;

    function automatic logic [15:0] mu0_instr(input logic [3:0] op, input logic [11:0] operand);
        return {op, operand};
    endfunction

endpackage

// File: rtl/mu0_byte_packer.sv
// Assembles a high-byte-first byte stream into 16-bit words; word_valid pulses
// for one cycle with the completed word held on word until the next completion.
module mu0_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_accept,
    input  logic [7:0]  byte_in,
    output logic        phase,
    output logic [15:0] word,
    output logic        word_valid
);

    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    always_comb begin
        phase_d      = phase_q;
        hi_d         = hi_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            phase_d = 1'b0;
        end else if (byte_accept) begin
            if (!phase_q) begin
                hi_d    = byte_in;
                phase_d = 1'b1;
            end else begin
                word_d       = {hi_q, byte_in};
                phase_d      = 1'b0;
                word_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= 1'b0;
            hi_q         <= 8'h00;
            word_q       <= 16'h0000;
            word_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign phase      = phase_q;
    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: rtl/mu0_boot_ctrl.sv
// MU0 run controller: loads a program image over a byte stream, holds/releases the
// core reset, muxes the memory port, and watches the run for Halted or a timeout.
module mu0_boot_ctrl
    import mu0_pkg::*;
#(
    parameter int ADDR_W     = MU0_ADDR_W,
    parameter int DATA_W     = MU0_DATA_W,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1000,
    parameter int RST_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Load_len,
    input  logic [7:0]        Byte_in,
    input  logic              Byte_valid,
    output logic              Byte_ready,
    input  logic              Cpu_rd,
    input  logic              Cpu_wr,
    input  logic [ADDR_W-1:0] Cpu_addr,
    input  logic [DATA_W-1:0] Cpu_data_out,
    input  logic              Cpu_halted,
    output logic              Cpu_reset,
    output logic              Mem_rd,
    output logic              Mem_wr,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_wdata,
    output logic              Busy,
    output logic              Done,
    output logic              Timeout,
    output logic [CNT_W-1:0]  Cycles,
    output logic [2:0]        Dbg_state
);

    // Load stream handshake: a byte moves on any cycle where Byte_valid and
    // Byte_ready are both high; Byte_ready is high only in LOAD, and the source
    // may hold Byte_valid low for any number of cycles without penalty.

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [CNT_W-1:0]  rel_q, rel_d;
    logic              timeout_q, timeout_d;

    logic              start_ok;
    logic              byte_accept;
    logic              pk_phase;
    logic [15:0]       pk_word;
    logic              pk_word_valid;

    assign start_ok    = Start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign byte_accept = Byte_valid && (state_q == ST_LOAD);

    mu0_byte_packer u_packer (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .clear       (start_ok),
        .byte_accept (byte_accept),
        .byte_in     (Byte_in),
        .phase       (pk_phase),
        .word        (pk_word),
        .word_valid  (pk_word_valid)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        cycles_d  = cycles_q;
        rel_d     = rel_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    len_d     = Load_len;
                    addr_d    = '0;
                    cycles_d  = '0;
                    rel_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = (Load_len != '0) ? ST_LOAD : ST_RELEASE;
                end
            end
            ST_LOAD: begin
                if (byte_accept && pk_phase) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q + ADDR_W'(1) == len_q) begin
                    rel_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RELEASE: begin
                if (rel_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_RUN;
                else rel_d = rel_q + CNT_W'(1);
            end
            ST_RUN: begin
                // Halt takes priority over watchdog expiry; the count freezes on exit.
                if (Cpu_halted) begin
                    timeout_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cycles_q == CNT_W'(MAX_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cycles_d = cycles_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            cycles_q  <= '0;
            rel_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            cycles_q  <= cycles_d;
            rel_q     <= rel_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        Cpu_reset = 1'b1;
        Mem_rd    = 1'b0;
        Mem_wr    = 1'b0;
        Mem_addr  = '0;
        Mem_wdata = '0;
        case (state_q)
            ST_WRITE: begin
                Mem_wr    = pk_word_valid;
                Mem_addr  = addr_q;
                Mem_wdata = DATA_W'(pk_word);
            end
            ST_RUN: begin
                Cpu_reset = 1'b0;
                Mem_rd    = Cpu_rd;
                Mem_wr    = Cpu_wr;
                Mem_addr  = Cpu_addr;
                Mem_wdata = Cpu_data_out;
            end
            ST_DONE: begin
                // After a clean halt the core stays out of reset so memory can be inspected.
                if (!timeout_q) begin
                    Cpu_reset = 1'b0;
                    Mem_rd    = Cpu_rd;
                    Mem_wr    = Cpu_wr;
                    Mem_addr  = Cpu_addr;
                    Mem_wdata = Cpu_data_out;
                end
            end
            default: ;
        endcase
    end

    assign Byte_ready = (state_q == ST_LOAD);
    assign Busy       = (state_q == ST_LOAD) || (state_q == ST_WRITE) ||
                        (state_q == ST_RELEASE) || (state_q == ST_RUN);
    assign Done       = (state_q == ST_DONE);
    assign Timeout    = timeout_q;
    assign Cycles     = cycles_q;
    assign Dbg_state  = state_q;

endmodule
